// File: rtl/io_frontend.sv
// Board I/O front end: synchronised switches, debounced buttons with press pulses,
// and a multiplexed seven-segment scanner. Define IO_FRONTEND_LZ_BLANK_EN to blank leading zeros.
module io_frontend #(
   parameter int N_BTN       = 5,
   parameter int N_SW        = 16,
   parameter int DIGITS      = 8,
   parameter int DEB_CYCLES  = 1000000,
   parameter int SCAN_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_BTN-1:0]    btn_in,
   input  logic [N_SW-1:0]     sw_in,
   output logic [N_BTN-1:0]    btn_level,
   output logic [N_BTN-1:0]    btn_pulse,
   output logic [N_SW-1:0]     sw_out,
   input  logic [4*DIGITS-1:0] disp_data,
   input  logic [DIGITS-1:0]   disp_dp,
   input  logic                disp_en,
   output logic [DIGITS-1:0]   anode,
   output logic [6:0]          cathode,
   output logic                dp
);

   localparam int DEB_W  = $clog2(DEB_CYCLES);
   localparam int SCAN_W = $clog2(SCAN_CYCLES);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   logic [N_BTN-1:0] r_btn_sync_p0;
   logic [N_BTN-1:0] r_btn_sync_p1;
   logic [N_SW-1:0]  r_sw_sync_p0;
   logic [N_SW-1:0]  r_sw_sync_p1;
   logic [N_BTN-1:0] r_btn_level;
   logic [N_BTN-1:0] r_btn_pulse;
   logic [DEB_W-1:0] r_deb_cnt [N_BTN];

   // Stage p0/p1: two-flop synchronisers for the raw asynchronous inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_sync_p0 <= '0;
         r_btn_sync_p1 <= '0;
         r_sw_sync_p0  <= '0;
         r_sw_sync_p1  <= '0;
      end else begin
         r_btn_sync_p0 <= btn_in;
         r_btn_sync_p1 <= r_btn_sync_p0;
         r_sw_sync_p0  <= sw_in;
         r_sw_sync_p1  <= r_sw_sync_p0;
      end
   end

   // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_level <= '0;
         r_btn_pulse <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            r_deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            r_btn_pulse[i] <= 1'b0;
            if (r_btn_sync_p1[i] == r_btn_level[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               r_btn_level[i] <= ~r_btn_level[i];
               r_btn_pulse[i] <= ~r_btn_level[i];
               r_deb_cnt[i]   <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign btn_level = r_btn_level;
   assign btn_pulse = r_btn_pulse;
   assign sw_out    = r_sw_sync_p1;

   logic [SCAN_W-1:0] r_pre;
   logic [IDX_W-1:0]  r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_idx <= '0;
      end else if (r_pre == SCAN_LAST) begin
         r_pre <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   logic w_lz_blank;

`ifdef IO_FRONTEND_LZ_BLANK_EN
   logic [DIGITS-1:0] w_zero_above;
   for (genvar g = 0; g < DIGITS; g++) begin : g_lz
      assign w_zero_above[g] = (disp_data[4*DIGITS-1:4*g] == '0);
   end
   assign w_lz_blank = (r_idx != '0) && w_zero_above[r_idx] && !disp_dp[r_idx];
`else
   assign w_lz_blank = 1'b0;
`endif

   logic [3:0]        w_nib;
   logic [DIGITS-1:0] w_anode;
   logic [6:0]        w_cathode;
   logic              w_dp;

   always_comb begin
      w_nib          = disp_data[4*r_idx +: 4];
      w_anode        = '1;
      w_anode[r_idx] = 1'b0;
      w_cathode      = hex7(w_nib);
      w_dp           = ~disp_dp[r_idx];
   end

   logic [DIGITS-1:0] r_anode;
   logic [6:0]        r_cathode;
   logic              r_dp;

   // Output stage: all segment drives are registered so the pins never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_anode   <= '1;
         r_cathode <= '1;
         r_dp      <= 1'b1;
      end else if (!disp_en || w_lz_blank) begin
         r_anode   <= '1;
         r_cathode <= '1;
         r_dp      <= 1'b1;
      end else begin
         r_anode   <= w_anode;
         r_cathode <= w_cathode;
         r_dp      <= w_dp;
      end
   end

   assign anode   = r_anode;
   assign cathode = r_cathode;
   assign dp      = r_dp;

endmodule

// File: tb/tb_io_frontend.sv
// Randomised and directed bench for io_frontend against a history-based reference model.
module tb_io_frontend;
   localparam int N_BTN  = 5;
   localparam int N_SW   = 16;
   localparam int DIGITS = 4;
   localparam int DEB    = 4;
   localparam int SCAN   = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_BTN-1:0]    btn_in;
   logic [N_SW-1:0]     sw_in;
   logic [N_BTN-1:0]    btn_level;
   logic [N_BTN-1:0]    btn_pulse;
   logic [N_SW-1:0]     sw_out;
   logic [4*DIGITS-1:0] disp_data;
   logic [DIGITS-1:0]   disp_dp;
   logic                disp_en;
   logic [DIGITS-1:0]   anode;
   logic [6:0]          cathode;
   logic                dp;

   io_frontend #(
      .N_BTN(N_BTN), .N_SW(N_SW), .DIGITS(DIGITS),
      .DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .sw_in(sw_in),
      .btn_level(btn_level), .btn_pulse(btn_pulse), .sw_out(sw_out),
      .disp_data(disp_data), .disp_dp(disp_dp), .disp_en(disp_en),
      .anode(anode), .cathode(cathode), .dp(dp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Segment patterns {g,f,e,d,c,b,a}, active low, for hex digits 0..F
   logic [6:0] seg_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   logic [N_SW-1:0]   m_sw_in1, m_sw_out;
   logic [N_BTN-1:0]  m_b_last, m_lvl, m_pulse;
   logic [N_BTN-1:0]  s2q [$];
   int                m_n;
   logic [DIGITS-1:0] m_anode;
   logic [6:0]        m_cath;
   logic              m_dp;

   task automatic model_reset();
      m_sw_in1 = '0;
      m_sw_out = '0;
      m_b_last = '0;
      m_lvl    = '0;
      m_pulse  = '0;
      s2q.delete();
      m_n      = 0;
      m_anode  = '1;
      m_cath   = '1;
      m_dp     = 1'b1;
   endtask

   task automatic model_edge();
      logic [N_BTN-1:0] s2_new, old;
      bit all_diff, blank;
      int idx;
      if (!rst_n) begin
         model_reset();
      end else begin
         m_sw_out = m_sw_in1;
         m_sw_in1 = sw_in;
         s2_new   = m_b_last;
         m_b_last = btn_in;
         old      = m_lvl;
         // A level change needs the last DEB synchronised samples all to differ from it
         if (s2q.size() == DEB) begin
            for (int i = 0; i < N_BTN; i++) begin
               all_diff = 1'b1;
               foreach (s2q[j]) if (s2q[j][i] == old[i]) all_diff = 1'b0;
               if (all_diff) m_lvl[i] = ~old[i];
            end
         end
         s2q.push_back(s2_new);
         if (s2q.size() > DEB) void'(s2q.pop_front());
         m_pulse = m_lvl & ~old;
         m_n++;
         idx = ((m_n - 1) / SCAN) % DIGITS;
         m_anode      = '1;
         m_anode[idx] = 1'b0;
         m_cath       = seg_tab[disp_data[4*idx +: 4]];
         m_dp         = ~disp_dp[idx];
         blank        = !disp_en;
`ifdef IO_FRONTEND_LZ_BLANK_EN
         if (idx > 0 && (disp_data >> (4*idx)) == 0 && !disp_dp[idx]) blank = 1'b1;
`endif
         if (blank) begin
            m_anode = '1;
            m_cath  = '1;
            m_dp    = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("sw_out",    32'(sw_out),    32'(m_sw_out));
      check_eq("btn_level", 32'(btn_level), 32'(m_lvl));
      check_eq("btn_pulse", 32'(btn_pulse), 32'(m_pulse));
      check_eq("anode",     32'(anode),     32'(m_anode));
      check_eq("cathode",   32'(cathode),   32'(m_cath));
      check_eq("dp",        32'(dp),        32'(m_dp));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_anode",   32'(anode),     32'hF);
      check_eq("rst_cathode", 32'(cathode),   32'h7F);
      check_eq("rst_dp",      32'(dp),        32'h1);
      check_eq("rst_level",   32'(btn_level), 32'h0);
      check_eq("rst_pulse",   32'(btn_pulse), 32'h0);
      check_eq("rst_sw",      32'(sw_out),    32'h0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [3:0]  exp_an [12];
   logic [6:0]  exp_ca [12];
   logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
   int          pcount;
   logic [3:0]  low_mask;

   initial begin
      btn_in    = '0;
      sw_in     = '0;
      disp_data = '0;
      disp_dp   = '0;
      disp_en   = 1'b1;
      rst_n     = 1'b1;
      #2;
      do_reset();

      // Switch path latency
      sw_in = 16'hA5C3;
      step();
      check_eq("sw_early", 32'(sw_out), 32'h0);
      step();
      check_eq("sw_t2", 32'(sw_out), 32'hA5C3);

      // Button 2 held: level rises after 2 + DEB edges, single pulse
      btn_in = 5'b00100;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k < 6) check_eq("btn2_early", 32'(btn_level[2]), 32'h0);
         if (k == 6) begin
            check_eq("btn2_rise",  32'(btn_level[2]), 32'h1);
            check_eq("btn2_pulse", 32'(btn_pulse[2]), 32'h1);
         end
         if (k == 7) check_eq("btn2_pulse_end", 32'(btn_pulse[2]), 32'h0);
      end
      btn_in = '0;
      pcount = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (btn_pulse != '0) pcount++;
      end
      check_eq("btn2_release_pulses", 32'(pcount), 32'h0);
      check_eq("btn2_released", 32'(btn_level[2]), 32'h0);

      // Button 0 bounce never completes a window
      pcount = 0;
      for (int k = 0; k < 15; k++) begin
         btn_in[0] = (k < 3 || (k >= 4 && k < 7)) ? 1'b1 : 1'b0;
         step();
         if (btn_level[0] || btn_pulse[0]) pcount++;
      end
      check_eq("btn0_bounce", 32'(pcount), 32'h0);

      // Scan sequence for 0x8F10
      disp_data = 16'h8F10;
      disp_dp   = '0;
      disp_en   = 1'b1;
      do_reset();
      for (int s = 0; s < 12; s++) begin
         exp_an[s] = ~(4'b0001 << (s / SCAN));
         case (s / SCAN)
            0:       exp_ca[s] = 7'b1000000;
            1:       exp_ca[s] = 7'b1111001;
            2:       exp_ca[s] = 7'b0001110;
            default: exp_ca[s] = 7'b0000000;
         endcase
      end
      for (int s = 0; s < 12; s++) begin
         step();
         check_eq("scan_anode",   32'(anode),   32'(exp_an[s]));
         check_eq("scan_cathode", 32'(cathode), 32'(exp_ca[s]));
      end

      // Leading-zero handling for 0x0007
      disp_data = 16'h0007;
      low_mask  = '0;
      for (int s = 0; s < 12; s++) begin
         step();
         low_mask |= ~anode;
      end
`ifdef IO_FRONTEND_LZ_BLANK_EN
      check_eq("lz_digits", 32'(low_mask), 32'h1);
`else
      check_eq("lz_digits", 32'(low_mask), 32'hF);
`endif

      // Reset mid-scan at index 2
      disp_data = 16'h8F10;
      do_reset();
      for (int s = 0; s < 7; s++) step();
      check_eq("pre_rst_anode", 32'(anode), 32'hB);
      do_reset();
      step();
      check_eq("post_rst_anode", 32'(anode), 32'hE);

      // Randomised traffic
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(5) == 0) btn_in[$urandom_range(N_BTN-1)] ^= 1'b1;
         if ($urandom_range(3) == 0) sw_in = 16'($urandom);
         if ($urandom_range(9) == 0) begin
            disp_data = 16'($urandom) & masks[$urandom_range(3)];
            disp_dp   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            disp_en   = ($urandom_range(7) != 0);
         end
         if (c == 400) do_reset();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/io_frontend.md
IO_FRONTEND -- requirements
Module: io_frontend

Interface
REQ-001 Parameter N_BTN, default 5, SHALL set the number of push-button inputs (range 1..8).
REQ-002 Parameter N_SW, default 16, SHALL set the number of slide-switch inputs (range 1..32).
REQ-003 Parameter DIGITS, default 8, SHALL set the number of seven-segment digits scanned (range 1..8).
REQ-004 Parameter DEB_CYCLES, default 1000000, SHALL set the debounce stability window in clk cycles (minimum 2).
REQ-005 Parameter SCAN_CYCLES, default 100000, SHALL set the dwell time per digit in clk cycles (minimum 2).
REQ-006 Ports SHALL be as follows; clock and reset are listed first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_in  in  N_BTN  raw buttons, asynchronous
- sw_in  in  N_SW  raw switches, asynchronous
- btn_level  out  N_BTN  debounced button level
- btn_pulse  out  N_BTN  one-cycle pulse on each debounced press
- sw_out  out  N_SW  synchronised switches
- disp_data  in  4*DIGITS  hex nibble per digit; digit i is [4i+3:4i]
- disp_dp  in  DIGITS  decimal point per digit, active high
- disp_en  in  1  0 blanks the whole display
- anode  out  DIGITS  digit select, active low; bit 0 is the rightmost digit
- cathode  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low

Function
REQ-007 btn_in and sw_in SHALL each pass through a two-flop synchroniser; sw_out SHALL equal sw_in delayed by exactly 2 cycles.
REQ-008 Each button SHALL have an independent counter that increments while its synchronised value differs from btn_level and clears while the two agree.
REQ-009 When the counter reaches DEB_CYCLES-1 with disagreement still present, btn_level SHALL toggle on the next edge and the counter SHALL clear; a change therefore needs DEB_CYCLES consecutive disagreeing cycles.
REQ-010 btn_pulse[i] SHALL be high for exactly the single cycle in which btn_level[i] is first 1 after a 0->1 transition; a release SHALL produce no pulse.
REQ-011 A bounce (return to agreement) before the window completes SHALL clear the counter with no output change.
REQ-012 A prescaler SHALL count 0..SCAN_CYCLES-1; at its terminal count the digit index SHALL advance, wrapping from DIGITS-1 to 0.
REQ-013 anode, cathode and dp SHALL be registered and SHALL reflect the current index and disp_data one cycle after either changes.
REQ-014 With disp_en=1, anode SHALL have only bit idx low, cathode SHALL be the hex decode of nibble idx, and dp SHALL be the inverse of disp_dp[idx].
REQ-015 Hex decode SHALL cover 0..F; for example 0 -> 1000000, 1 -> 1111001, 8 -> 0000000, F -> 0001110.
REQ-016 With disp_en=0, anode, cathode and dp SHALL be all ones one cycle later while the scan counters keep running.
REQ-017 disp_data changes mid-dwell SHALL take effect on the next cycle without restarting the dwell.

Reset
REQ-018 Asserting rst_n low SHALL immediately clear all synchronisers, debounce counters, btn_level, btn_pulse, sw_out, the prescaler and the digit index.
REQ-019 During reset, anode, cathode and dp SHALL be all ones; after release the scan SHALL start at digit 0 with a full SCAN_CYCLES dwell.
REQ-020 Reset asserted mid-debounce SHALL discard partial counts; after release a new full window SHALL be required.

Configuration
REQ-021 With macro IO_FRONTEND_LZ_BLANK_EN defined, digit idx>0 SHALL be blanked (anode bit high, cathode and dp all ones) when nibble idx and all higher nibbles are 0 and disp_dp[idx]=0.
REQ-022 Without IO_FRONTEND_LZ_BLANK_EN, every digit SHALL be displayed, including leading zeros; digit 0 SHALL never be blanked by this feature.

Verification (DIGITS=4, DEB_CYCLES=4, SCAN_CYCLES=3, N_BTN=5, N_SW=16)
REQ-023 The bench SHALL cover these directed scenarios:
- sw_in 0x0000 -> 0xA5C3 at cycle t -> sw_out=0xA5C3 at t+2 and not before.
- btn_in[2] held high -> btn_level[2] rises after 2+4 cycles; btn_pulse[2] high exactly 1 cycle; no pulse on release.
- btn_in[0] high 3 cycles, low 1, high 3 -> btn_level[0] stays 0 and btn_pulse stays 0.
- disp_data=0x8F10, disp_en=1 -> anode cycles 1110, 1101, 1011, 0111, each for 3 cycles; cathode sequence 1000000, 1111001, 0001110, 0000000.
- disp_data=0x0007 with IO_FRONTEND_LZ_BLANK_EN -> only anode 1110 is ever low; without the macro, all four digits are shown and digits 1..3 show 1000000.
- rst_n pulsed low mid-scan at idx=2 -> outputs are all ones asynchronously; after release, anode=1110 on the first registered cycle.
